// File: rtl/subservient_sram_arb.sv
// subservient_sram_arb: shares the single byte-wide SRAM between the core's
// byte port and the host Wishbone word port. Host words are split into one
// SRAM cycle per selected byte lane; core bytes pass through one at a time.
// All outputs are registered.
// Build option: define SUBSERVIENT_ARB_RR_EN for round-robin tie-breaking;
// otherwise the host wins every tie.
module subservient_sram_arb #(
  parameter int unsigned AW = 10
) (
  input  logic          wb_clk_i,
  input  logic          wb_rstn_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_adr_i,
  input  logic [7:0]    core_dat_i,
  output logic          core_ack_o,
  output logic [7:0]    core_dat_o,
  output logic          sram_en_o,
  output logic          sram_we_o,
  output logic [AW-1:0] sram_adr_o,
  output logic [7:0]    sram_dat_o,
  input  logic [7:0]    sram_dat_i
);

`ifdef SUBSERVIENT_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    C_ISSUE,
    C_WAIT,
    C_ACK,
    H_ISSUE,
    H_WAIT,
    H_ACK
  } state_t;

  state_t      state;
  logic        last_core;   // 1: last grant went to the core, 0: to the host
  logic [3:0]  lane_mask;   // host lanes still to be issued
  logic        xfer_we;     // write flag of the transfer in progress
  logic        aborted;     // host dropped cyc mid-word: no ack
  logic        rd_ret;      // a host read lane returns data this cycle
  logic [1:0]  ret_lane;    // lane whose read data is returning

  logic        host_req;
  logic        grant_core;
  logic [1:0]  first_lane;
  logic [1:0]  next_lane;
  logic        unused_adr_lsb;

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0])      low_lane = 2'd0;
    else if (m[1]) low_lane = 2'd1;
    else if (m[2]) low_lane = 2'd2;
    else           low_lane = 2'd3;
  endfunction

  // Request decode, tie-break and lane selection
  always_comb begin
    host_req       = wbs_cyc_i & wbs_stb_i;
    grant_core     = core_req_i & (~host_req | (RR_EN & ~last_core));
    first_lane     = low_lane(wbs_sel_i);
    next_lane      = low_lane(lane_mask);
    unused_adr_lsb = ^wbs_adr_i[1:0];
  end

  // Arbitration and SRAM sequencing FSM with registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state      <= IDLE;
      last_core  <= 1'b0;
      lane_mask  <= '0;
      xfer_we    <= 1'b0;
      aborted    <= 1'b0;
      rd_ret     <= 1'b0;
      ret_lane   <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      core_ack_o <= 1'b0;
      core_dat_o <= '0;
      sram_en_o  <= 1'b0;
      sram_we_o  <= 1'b0;
      sram_adr_o <= '0;
      sram_dat_o <= '0;
    end else begin
      sram_en_o  <= 1'b0;
      sram_we_o  <= 1'b0;
      wbs_ack_o  <= 1'b0;
      core_ack_o <= 1'b0;
      // SRAM read data follows its issue cycle by one; the lane is the
      // low address bits of the cycle that was issued.
      rd_ret     <= sram_en_o & ~sram_we_o & (state == H_ISSUE);
      ret_lane   <= sram_adr_o[1:0];

      unique case (state)
        IDLE: begin
          if (grant_core) begin
            last_core  <= 1'b1;
            xfer_we    <= core_we_i;
            sram_en_o  <= 1'b1;
            sram_we_o  <= core_we_i;
            sram_adr_o <= core_adr_i;
            sram_dat_o <= core_dat_i;
            state      <= C_ISSUE;
          end else if (host_req) begin
            last_core <= 1'b0;
            xfer_we   <= wbs_we_i;
            aborted   <= 1'b0;
            if (!wbs_we_i)
              wbs_dat_o <= '0;
            if (wbs_sel_i != 4'b0000) begin
              sram_en_o  <= 1'b1;
              sram_we_o  <= wbs_we_i;
              sram_adr_o <= {wbs_adr_i[AW-1:2], first_lane};
              sram_dat_o <= wbs_dat_i[{first_lane, 3'b000} +: 8];
              lane_mask  <= wbs_sel_i & ~(4'b0001 << first_lane);
              state      <= H_ISSUE;
            end else begin
              wbs_ack_o <= 1'b1;
              state     <= H_ACK;
            end
          end
        end

        C_ISSUE: state <= C_WAIT;

        C_WAIT: begin
          if (!xfer_we)
            core_dat_o <= sram_dat_i;
          core_ack_o <= 1'b1;
          state      <= C_ACK;
        end

        C_ACK: state <= IDLE;

        H_ISSUE: begin
          if (rd_ret)
            wbs_dat_o[{ret_lane, 3'b000} +: 8] <= sram_dat_i;
          if (!wbs_cyc_i) begin
            aborted <= 1'b1;
            state   <= H_WAIT;
          end else if (lane_mask != 4'b0000) begin
            sram_en_o  <= 1'b1;
            sram_we_o  <= xfer_we;
            sram_adr_o <= {wbs_adr_i[AW-1:2], next_lane};
            sram_dat_o <= wbs_dat_i[{next_lane, 3'b000} +: 8];
            lane_mask  <= lane_mask & ~(4'b0001 << next_lane);
          end else begin
            state <= H_WAIT;
          end
        end

        H_WAIT: begin
          if (rd_ret)
            wbs_dat_o[{ret_lane, 3'b000} +: 8] <= sram_dat_i;
          if (aborted) begin
            state <= IDLE;
          end else begin
            wbs_ack_o <= 1'b1;
            state     <= H_ACK;
          end
        end

        H_ACK: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
